// File: rtl/sirius_pkg.sv
// Shared definitions for the Sirius MIPS core: COP0 exception codes, the
// default exception vector and the commit-stage controller state encoding.
package sirius_pkg;

  typedef enum logic [4:0] {
    INT  = 5'd0,
    ADEL = 5'd4,
    ADES = 5'd5,
    SYS  = 5'd8,
    BP   = 5'd9,
    RI   = 5'd10,
    OV   = 5'd12
  } exc_code_t;

  // Which address COP0 should record as BadVAddr for the winning exception.
  typedef enum logic [1:0] {
    BAD_NONE = 2'd0,
    BAD_PC   = 2'd1,
    BAD_MEM  = 2'd2
  } bad_sel_t;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } ctrl_state_t;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder: picks the highest-priority raised cause
// and reports its COP0 code and which address feeds BadVAddr.
module exc_prio_enc
  import sirius_pkg::*;
(
  input  logic      int_pend,
  input  logic      f_adel,
  input  logic      f_ri,
  input  logic      f_ov,
  input  logic      f_sys,
  input  logic      f_bp,
  input  logic      f_adel_ld,
  input  logic      f_ades,
  output logic      hit,
  output exc_code_t code,
  output bad_sel_t  bad_sel
);

  always_comb begin
    hit     = 1'b1;
    code    = INT;
    bad_sel = BAD_NONE;
    if (int_pend) begin
      code = INT;
    end else if (f_adel) begin
      code    = ADEL;
      bad_sel = BAD_PC;
    end else if (f_ri) begin
      code = RI;
    end else if (f_ov) begin
      code = OV;
    end else if (f_sys) begin
      code = SYS;
    end else if (f_bp) begin
      code = BP;
    end else if (f_adel_ld) begin
      code    = ADEL;
      bad_sel = BAD_MEM;
    end else if (f_ades) begin
      code    = ADES;
      bad_sel = BAD_MEM;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Commit-stage exception/ERET arbiter: drives COP0 capture inputs in the
// commit cycle, flushes the pipeline and holds a PC redirect until fetch takes it.
module exception_ctrl
  import sirius_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic        mem_stall,
  input  logic [31:0] pc,
  input  logic        in_delay_slot,
  input  logic [31:0] mem_addr,
  input  logic        f_adel,
  input  logic        f_ri,
  input  logic        f_ov,
  input  logic        f_sys,
  input  logic        f_bp,
  input  logic        f_adel_ld,
  input  logic        f_ades,
  input  logic        f_eret,
  input  logic        allow_interrupt,
  input  logic [7:0]  interrupt_flag,
  input  logic [31:0] epc_address,
  output logic        exp_en,
  output logic        exp_badvaddr_en,
  output logic [31:0] exp_badvaddr,
  output logic        exp_bd,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_epc,
  output logic        exl_clean,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  ctrl_state_t state_q, state_d;
  logic        int_pend_q, int_pend_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        commit;
  logic        take_exc;
  logic        take_eret;
  logic        prio_hit;
  exc_code_t   prio_code;
  bad_sel_t    prio_bad_sel;

  exc_prio_enc u_prio_enc (
    .int_pend  (int_pend_q),
    .f_adel    (f_adel),
    .f_ri      (f_ri),
    .f_ov      (f_ov),
    .f_sys     (f_sys),
    .f_bp      (f_bp),
    .f_adel_ld (f_adel_ld),
    .f_ades    (f_ades),
    .hit       (prio_hit),
    .code      (prio_code),
    .bad_sel   (prio_bad_sel)
  );

  always_comb begin
    // Gating with rst keeps every COP0 output quiet while reset is held.
    commit    = inst_valid & ~mem_stall & (state_q == IDLE) & ~rst;
    take_exc  = commit & prio_hit;
    take_eret = commit & ~prio_hit & f_eret;

    exp_en          = 1'b0;
    exp_badvaddr_en = 1'b0;
    exp_badvaddr    = 32'd0;
    exp_bd          = 1'b0;
    exp_code        = 5'd0;
    exp_epc         = 32'd0;
    exl_clean       = 1'b0;
    redirect_pc_d   = redirect_pc_q;
    state_d         = state_q;

    if (take_exc) begin
      exp_en          = 1'b1;
      exp_code        = prio_code;
      exp_bd          = in_delay_slot;
      exp_epc         = in_delay_slot ? (pc - 32'd4) : pc;
      exp_badvaddr_en = (prio_bad_sel != BAD_NONE);
      exp_badvaddr    = (prio_bad_sel == BAD_PC)  ? pc :
                        (prio_bad_sel == BAD_MEM) ? mem_addr : 32'd0;
      redirect_pc_d   = EXC_VECTOR;
    end else if (take_eret) begin
      exp_en        = 1'b1;
      exl_clean     = 1'b1;
      exp_epc       = epc_address;
      redirect_pc_d = epc_address;
    end

    unique case (state_q)
      IDLE:     if (take_exc || take_eret) state_d = REDIRECT;
      REDIRECT: if (redirect_ready)        state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    int_pend_d     = allow_interrupt & (|interrupt_flag);
    flush          = take_exc | take_eret | (state_q == REDIRECT);
    redirect_valid = (state_q == REDIRECT);
    redirect_pc    = redirect_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      int_pend_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      int_pend_q    <= int_pend_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: directed scenarios followed by random
// traffic, checked each cycle against a cause-table reference model.
module tb_exception_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, inst_valid, mem_stall, in_delay_slot;
  logic [31:0] pc, mem_addr, epc_address;
  logic        f_adel, f_ri, f_ov, f_sys, f_bp, f_adel_ld, f_ades, f_eret;
  logic        allow_interrupt, redirect_ready;
  logic [7:0]  interrupt_flag;
  logic        exp_en, exp_badvaddr_en, exp_bd, exl_clean, flush, redirect_valid;
  logic [31:0] exp_badvaddr, exp_epc, redirect_pc;
  logic [4:0]  exp_code;

  exception_ctrl dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .mem_stall(mem_stall),
    .pc(pc), .in_delay_slot(in_delay_slot), .mem_addr(mem_addr),
    .f_adel(f_adel), .f_ri(f_ri), .f_ov(f_ov), .f_sys(f_sys), .f_bp(f_bp),
    .f_adel_ld(f_adel_ld), .f_ades(f_ades), .f_eret(f_eret),
    .allow_interrupt(allow_interrupt), .interrupt_flag(interrupt_flag),
    .epc_address(epc_address), .exp_en(exp_en), .exp_badvaddr_en(exp_badvaddr_en),
    .exp_badvaddr(exp_badvaddr), .exp_bd(exp_bd), .exp_code(exp_code),
    .exp_epc(exp_epc), .exl_clean(exl_clean), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  // f bits: 0 fetch AdEL, 1 RI, 2 Ov, 3 Sys, 4 Bp, 5 load AdEL, 6 AdES
  typedef struct {
    logic        rst, iv, stall, ids, eret, allow, rdy;
    logic [31:0] pc, maddr, epc;
    logic [6:0]  f;
    logic [7:0]  iflag;
  } stim_t;

  typedef struct {
    logic        en, bad_en, bd, exl, flush, rv;
    logic [31:0] bad, epc, rpc;
    logic [4:0]  code;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state: are we waiting on fetch, where to, pending interrupt.
  logic        m_busy = 1'b0;
  logic        m_int  = 1'b0;
  logic [31:0] m_tgt  = 32'd0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst = 0; s.iv = 0; s.stall = 0; s.ids = 0; s.eret = 0; s.allow = 0; s.rdy = 0;
    s.pc = 0; s.maddr = 0; s.epc = 0; s.f = 0; s.iflag = 0;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t        e;
    logic        act [8];
    int          codes [8] = '{0, 4, 10, 12, 8, 9, 4, 5};
    int          bsel  [8] = '{0, 1, 0, 0, 0, 0, 2, 2};
    int          win;
    logic        commit, go;
    logic [31:0] nt;

    @(posedge clk); #1;
    rst = s.rst; inst_valid = s.iv; mem_stall = s.stall; in_delay_slot = s.ids;
    pc = s.pc; mem_addr = s.maddr; epc_address = s.epc;
    {f_ades, f_adel_ld, f_bp, f_sys, f_ov, f_ri, f_adel} = s.f;
    f_eret = s.eret; allow_interrupt = s.allow; interrupt_flag = s.iflag;
    redirect_ready = s.rdy;

    e = '{default: '0};
    e.rv = m_busy; e.flush = m_busy; e.rpc = m_tgt;
    commit = !s.rst && s.iv && !s.stall && !m_busy;
    act[0] = m_int;
    for (int i = 1; i < 8; i++) act[i] = s.f[i-1];
    win = -1;
    for (int i = 0; i < 8; i++) if (act[i] && win < 0) win = i;
    go = 0; nt = 0;
    if (commit && win >= 0) begin
      e.en = 1; e.code = 5'(codes[win]); e.bd = s.ids;
      e.epc = s.ids ? s.pc - 32'd4 : s.pc;
      e.bad_en = (bsel[win] != 0);
      e.bad = (bsel[win] == 1) ? s.pc : (bsel[win] == 2) ? s.maddr : 32'd0;
      e.flush = 1; go = 1; nt = 32'hBFC0_0380;
    end else if (commit && s.eret) begin
      e.en = 1; e.exl = 1; e.epc = s.epc; e.flush = 1; go = 1; nt = s.epc;
    end
    sb_q.push_back(e);

    if (s.rst) begin
      m_busy = 0; m_tgt = 0; m_int = 0;
    end else begin
      m_int = s.allow && (s.iflag != 0);
      if (m_busy) begin
        if (s.rdy) m_busy = 0;
      end else if (go) begin
        m_busy = 1; m_tgt = nt;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("exp_en",          {31'd0, exp_en},          {31'd0, e.en});
        chk("exp_code",        {27'd0, exp_code},        {27'd0, e.code});
        chk("exp_epc",         exp_epc,                  e.epc);
        chk("exp_bd",          {31'd0, exp_bd},          {31'd0, e.bd});
        chk("exp_badvaddr_en", {31'd0, exp_badvaddr_en}, {31'd0, e.bad_en});
        chk("exp_badvaddr",    exp_badvaddr,             e.bad);
        chk("exl_clean",       {31'd0, exl_clean},       {31'd0, e.exl});
        chk("flush",           {31'd0, flush},           {31'd0, e.flush});
        chk("redirect_valid",  {31'd0, redirect_valid},  {31'd0, e.rv});
        chk("redirect_pc",     redirect_pc,              e.rpc);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stimulus
    stim_t s;
    rst = 1; inst_valid = 0; mem_stall = 0; in_delay_slot = 0; pc = 0; mem_addr = 0;
    epc_address = 0; f_adel = 0; f_ri = 0; f_ov = 0; f_sys = 0; f_bp = 0;
    f_adel_ld = 0; f_ades = 0; f_eret = 0; allow_interrupt = 0; interrupt_flag = 0;
    redirect_ready = 0;
    repeat (2) @(posedge clk);

    s = idle_stim(); s.rst = 1; s.iv = 1; s.f = 7'h7F; step(s);

    // Overflow, then redirect held for two cycles before fetch accepts
    s = idle_stim(); s.iv = 1; s.pc = 32'h8000_0100; s.f[2] = 1; step(s);
    s = idle_stim(); step(s); step(s);
    s.rdy = 1; step(s);
    s = idle_stim(); step(s);

    // Store address error in a delay slot
    s = idle_stim(); s.iv = 1; s.pc = 32'h8000_0204; s.ids = 1; s.f[6] = 1;
    s.maddr = 32'h0000_1001; step(s);
    s = idle_stim(); s.rdy = 1; step(s);

    // Fetch AdEL beats RI and Sys
    s = idle_stim(); s.iv = 1; s.pc = 32'h0000_0003; s.f[0] = 1; s.f[1] = 1; s.f[3] = 1; step(s);
    s = idle_stim(); s.rdy = 1; step(s);

    // ERET
    s = idle_stim(); s.iv = 1; s.eret = 1; s.epc = 32'h8000_0400; step(s);
    s = idle_stim(); step(s);
    s.rdy = 1; step(s);

    // Interrupt sampled in K, taken on the commit in K+1
    s = idle_stim(); s.iv = 1; s.pc = 32'h8000_0500; s.allow = 1; s.iflag = 8'h04; step(s);
    step(s);
    s = idle_stim(); s.rdy = 1; step(s);

    // Stall blocks commit; exception during REDIRECT ignored; reset in REDIRECT
    s = idle_stim(); s.iv = 1; s.stall = 1; s.f[4] = 1; s.pc = 32'h8000_0600; step(s);
    s.stall = 0; step(s);
    s = idle_stim(); s.iv = 1; s.f[2] = 1; s.pc = 32'h8000_0700; step(s);
    s = idle_stim(); s.rst = 1; step(s);
    s = idle_stim(); step(s);

    for (int n = 0; n < 400; n++) begin
      s = idle_stim();
      s.rst   = ($urandom % 50) == 0;
      s.iv    = ($urandom % 4) != 0;
      s.stall = ($urandom % 4) == 0;
      s.ids   = $urandom % 2;
      s.pc    = $urandom;
      s.maddr = $urandom;
      s.epc   = $urandom;
      for (int b = 0; b < 7; b++) s.f[b] = ($urandom % 8) == 0;
      s.eret  = ($urandom % 6) == 0;
      s.allow = $urandom % 2;
      s.iflag = (($urandom % 3) == 0) ? 8'($urandom) : 8'd0;
      s.rdy   = ($urandom % 3) == 0;
      step(s);
    end

    @(negedge clk); #1;
    chk("scoreboard_drain", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
